uv_mqueue: RTL
==============

Name: uv_mqueue

Overview:
- Multi-channel FIFO: CH_NUM independent queues in one banked storage array, with one shared write port and one shared read port, each steered by a channel index.
- Each channel has its own pointers, length, almost-full/almost-empty flags, per-channel clear and sticky overflow/underflow flags.
- Sits between a multi-source producer (e.g. per-hart or per-ID request streams) and an arbitrated consumer.
- Replaces N separate single-channel queues.

Parameters:
DAT_WIDTH, 32, data width per entry
PTR_WIDTH, 3, per-channel pointer width; per-channel depth QUE_DEPTH = 2**PTR_WIDTH
CH_NUM, 4, number of channels (2..16)
CH_WIDTH, 2, channel index width; must satisfy 2**CH_WIDTH >= CH_NUM
ZERO_RDLY, 1, 1: rd_dat is combinational head of rd_ch; 0: rd_dat registered on read fire
AFULL_LVL, QUE_DEPTH-1, afull asserted when len >= AFULL_LVL (1..QUE_DEPTH)
AEMPTY_LVL, 1, aempty asserted when len <= AEMPTY_LVL (0..QUE_DEPTH-1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
wr_vld  in  1  write request
wr_ch  in  CH_WIDTH  target channel of write
wr_dat  in  DAT_WIDTH  write data
wr_rdy  out  1  selected write channel can accept
rd_vld  in  1  read (pop) request
rd_ch  in  CH_WIDTH  channel to pop
rd_dat  out  DAT_WIDTH  read data
rd_rdy  out  1  selected read channel has data
clr  in  CH_NUM  per-channel synchronous clear
len  out  CH_NUM*(PTR_WIDTH+1)  packed per-channel lengths, channel c at [c*(PTR_WIDTH+1) +: PTR_WIDTH+1]
full  out  CH_NUM  len == QUE_DEPTH
empty  out  CH_NUM  len == 0
afull  out  CH_NUM  len >= AFULL_LVL
aempty  out  CH_NUM  len <= AEMPTY_LVL
ovf  out  CH_NUM  sticky: write dropped on full channel
udf  out  CH_NUM  sticky: read on empty channel

Behaviour:
- Reset (rst=1, async) sets all pointers, len, ovf and udf to 0. Resulting outputs: empty=all 1, full=0, afull=0, aempty=all 1. rd_dat=0 when ZERO_RDLY=0. Storage is not reset.
- Channel index is valid when < CH_NUM.
  - Invalid wr_ch: wr_rdy=0 and the write is dropped with no flag.
  - Invalid rd_ch: rd_rdy=0, rd_dat=0 (ZERO_RDLY=1), and the pop is ignored.
- Fire conditions (w = wr_ch, r = rd_ch):
  - wr_fire = wr_vld & valid(w) & (clr[w] | ~full[w]).
  - rd_fire = rd_vld & valid(r) & ~clr[r] & ~empty[r].
- Handshakes:
  - wr_rdy = valid(w) & (clr[w] | ~full[w]).
  - rd_rdy = valid(r) & ~clr[r] & ~empty[r].
  - Both are combinational from the current state and inputs; neither depends on its own vld.
- Storage: entry (c, p) lives at flat index c*QUE_DEPTH + p. A write stores at wr_ptr[w].
- Pointer wrap: pointers increment modulo QUE_DEPTH. With a power-of-two depth this is natural PTR_WIDTH-bit overflow.
- Length, per channel c:
  - +1 on write-only.
  - −1 on read-only.
  - Unchanged on simultaneous write and read to c, or with no activity.
  - Writes and reads to different channels update independently in the same cycle.
- Full channel: a same-cycle pop does not free space for a same-cycle write; wr_rdy uses the registered full.
- Clear of channel c:
  - Next cycle: wr_ptr=0, rd_ptr=0, len=0, ovf[c]=0, udf[c]=0.
  - If the same cycle has wr_fire to c: data is stored at index 0, wr_ptr=1, len=1.
  - A same-cycle pop of c is suppressed.
- Sticky flags (cleared only by rst or clr[c]):
  - ovf[c] sets on wr_vld & w==c & full[c] & ~clr[c].
  - udf[c] sets on rd_vld & r==c & empty[c] & ~clr[c].
- Read data:
  - ZERO_RDLY=1: rd_dat = que[r, rd_ptr[r]] combinationally; valid while rd_rdy=1.
  - ZERO_RDLY=0: rd_dat registers the popped entry on rd_fire, valid the cycle after fire, held until the next rd_fire.
- Write then read of the same entry: a write at cycle t is visible to a read at t+1 or later.
- afull, aempty, full, empty are decoded from the registered len (one cycle after the causing fire).
- Reset asserted mid-operation: all channels empty immediately; in-flight fires are discarded.

Test Plan:
- Reset, then write 8 entries 0x10..0x17 to ch2 (QUE_DEPTH=8) → full[2]=1 and afull[2]=1 after 7th write; 9th write → wr_rdy=0, ovf[2]=1, len2 stays 8. Pop 8 from ch2 → data 0x10..0x17 in order, empty[2]=1.
- Interleaved writes ch0=0xA0, ch1=0xB0, ch0=0xA1; pop ch1 then ch0 twice → 0xB0, 0xA0, 0xA1; ch3 untouched, empty[3]=1.
- Ch1 holds 3 entries; same cycle write ch1 plus pop ch1 → len1 stays 3, popped data is the oldest entry. Repeat 20 times → pointers wrap and FIFO order is preserved.
- Ch0 holds 5 entries and ovf[0]=1; assert clr[0] together with write 0x55 to ch0 and pop ch0 → next cycle len0=1, ovf[0]=0, the pop is ignored, the next pop returns 0x55.
- Pop empty ch3 → rd_rdy=0, udf[3]=1, len3=0. Use rd_ch=CH_NUM (when CH_NUM < 2**CH_WIDTH) → rd_rdy=0 and no state change. Assert rst mid-stream with ch0 len=4 → len0=0 immediately and udf=0.
- ZERO_RDLY=0 build: write 0x99 to ch0, pop → rd_dat=0x99 exactly one cycle after fire and held until the next fire.

Source files
------------

// File: rtl/uv_mqueue.sv
// uv_mqueue: multi-channel FIFO. CH_NUM queues share one banked storage array,
// one write port and one read port, each steered by a channel index.
module uv_mqueue #(
    parameter int DAT_WIDTH  = 32,
    parameter int PTR_WIDTH  = 3,
    parameter int CH_NUM     = 4,
    parameter int CH_WIDTH   = 2,
    parameter bit ZERO_RDLY  = 1,
    parameter int AFULL_LVL  = (1 << PTR_WIDTH) - 1,
    parameter int AEMPTY_LVL = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_vld,
    input  logic [CH_WIDTH-1:0]             wr_ch,
    input  logic [DAT_WIDTH-1:0]            wr_dat,
    output logic                            wr_rdy,
    input  logic                            rd_vld,
    input  logic [CH_WIDTH-1:0]             rd_ch,
    output logic [DAT_WIDTH-1:0]            rd_dat,
    output logic                            rd_rdy,
    input  logic [CH_NUM-1:0]               clr,
    output logic [CH_NUM*(PTR_WIDTH+1)-1:0] len,
    output logic [CH_NUM-1:0]               full,
    output logic [CH_NUM-1:0]               empty,
    output logic [CH_NUM-1:0]               afull,
    output logic [CH_NUM-1:0]               aempty,
    output logic [CH_NUM-1:0]               ovf,
    output logic [CH_NUM-1:0]               udf
);
    localparam int QUE_DEPTH = 1 << PTR_WIDTH;
    localparam int LW        = PTR_WIDTH + 1;
    localparam int AW        = $clog2(CH_NUM * QUE_DEPTH);
    localparam logic [LW-1:0]        DEPTH_L = LW'(QUE_DEPTH);
    localparam logic [LW-1:0]        AF_L    = LW'(AFULL_LVL);
    localparam logic [LW-1:0]        AE_L    = LW'(AEMPTY_LVL);
    localparam logic [LW-1:0]        CNT_ONE = LW'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

    logic [PTR_WIDTH-1:0] wr_ptr [CH_NUM];
    logic [PTR_WIDTH-1:0] rd_ptr [CH_NUM];
    logic [LW-1:0]        cnt    [CH_NUM];
    logic [DAT_WIDTH-1:0] mem    [CH_NUM*QUE_DEPTH];

    logic [CH_NUM-1:0]    wr_hit, rd_hit, wr_fire_c, rd_fire_c;
    logic [PTR_WIDTH-1:0] wr_slot, rd_slot;
    logic [AW-1:0]        waddr, raddr;
    logic [DAT_WIDTH-1:0] rd_head;

    // Channel decode: an out-of-range index hits no channel, so it can never fire.
    always_comb begin
        wr_hit    = '0;
        rd_hit    = '0;
        wr_fire_c = '0;
        rd_fire_c = '0;
        wr_slot   = '0;
        rd_slot   = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            wr_hit[c]    = (wr_ch == CH_WIDTH'(c));
            rd_hit[c]    = (rd_ch == CH_WIDTH'(c));
            // Full uses registered state: a same-cycle pop does not make room.
            wr_fire_c[c] = wr_vld & wr_hit[c] & (clr[c] | ~full[c]);
            rd_fire_c[c] = rd_vld & rd_hit[c] & ~clr[c] & ~empty[c];
            // A clear restarts the channel, so a concurrent write lands in slot 0.
            if (wr_hit[c]) wr_slot = clr[c] ? '0 : wr_ptr[c];
            if (rd_hit[c]) rd_slot = rd_ptr[c];
        end
    end

    // Handshakes and flat addresses; {ch, ptr} equals ch*QUE_DEPTH + ptr.
    always_comb begin
        wr_rdy  = |(wr_hit & (clr | ~full));
        rd_rdy  = |(rd_hit & ~clr & ~empty);
        waddr   = AW'({wr_ch, wr_slot});
        raddr   = AW'({rd_ch, rd_slot});
        rd_head = (|rd_hit) ? mem[raddr] : '0;
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (|wr_fire_c) mem[waddr] <= wr_dat;
    end

    // Per-channel pointers, length and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH_NUM; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                cnt[c]    <= '0;
            end
            ovf <= '0;
            udf <= '0;
        end else begin
            for (int c = 0; c < CH_NUM; c++) begin
                if (clr[c]) begin
                    wr_ptr[c] <= wr_fire_c[c] ? PTR_ONE : '0;
                    cnt[c]    <= wr_fire_c[c] ? CNT_ONE : '0;
                    rd_ptr[c] <= '0;
                    ovf[c]    <= 1'b0;
                    udf[c]    <= 1'b0;
                end else begin
                    if (wr_fire_c[c]) wr_ptr[c] <= wr_ptr[c] + PTR_ONE;
                    if (rd_fire_c[c]) rd_ptr[c] <= rd_ptr[c] + PTR_ONE;
                    case ({wr_fire_c[c], rd_fire_c[c]})
                        2'b10:   cnt[c] <= cnt[c] + CNT_ONE;
                        2'b01:   cnt[c] <= cnt[c] - CNT_ONE;
                        default: cnt[c] <= cnt[c];
                    endcase
                    if (wr_vld & wr_hit[c] & full[c])  ovf[c] <= 1'b1;
                    if (rd_vld & rd_hit[c] & empty[c]) udf[c] <= 1'b1;
                end
            end
        end
    end

    // Level flags decoded from the registered lengths.
    always_comb begin
        len    = '0;
        full   = '0;
        empty  = '0;
        afull  = '0;
        aempty = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            len[c*LW +: LW] = cnt[c];
            full[c]         = (cnt[c] == DEPTH_L);
            empty[c]        = (cnt[c] == '0);
            afull[c]        = (cnt[c] >= AF_L);
            aempty[c]       = (cnt[c] <= AE_L);
        end
    end

    generate
        if (ZERO_RDLY) begin : g_comb_rd
            assign rd_dat = rd_head;
        end else begin : g_reg_rd
            logic [DAT_WIDTH-1:0] rd_q;
            // Capture the popped entry; held until the next pop.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)             rd_q <= '0;
                else if (|rd_fire_c) rd_q <= rd_head;
            end
            assign rd_dat = rd_q;
        end
    endgenerate

endmodule
